multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide port clk_i  in  1  system clock, rising-edge active.
REQ-002 SHALL provide port rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide port instr_op_i  in  6  opcode of the latched instruction register.
REQ-004 SHALL provide port mem_ready_i  in  1  memory access complete this cycle.
REQ-005 SHALL provide outputs, each 1 bit: PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o.
REQ-006 SHALL provide outputs PCSource_o 2 bits (0=ALU result, 1=ALUOut, 2=jump target) and ALUSrcB_o 2 bits (0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2).
REQ-007 SHALL provide output ALU_op_o 3 bits: 0=add, 2=addi, 4=R-type (funct decides), 5=beq/sub, 7=sltiu.
REQ-008 SHALL provide outputs instr_done_o 1 bit (one-cycle pulse on retire) and trap_o 1 bit (sticky illegal-opcode flag).

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, TRAP.
REQ-010 FETCH SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=0, PCSource=0; IRWrite and PCWrite SHALL be asserted only while mem_ready_i=1.
REQ-011 FETCH SHALL hold while mem_ready_i=0 and advance to DECODE on the cycle mem_ready_i=1.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ALU_op=0 (branch target) and branch on instr_op_i: 0->EXEC_R, 35/43->MEM_ADDR, 4->BRANCH, 8/9->EXEC_I, 2->JUMP, any other->TRAP.
REQ-013 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=2, ALU_op=0, then go to MEM_RD for op 35, MEM_WR for op 43.
REQ-014 MEM_RD SHALL drive MemRead=1, IorD=1, hold while mem_ready_i=0, then go to MEM_WB.
REQ-015 MEM_WB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0; retire.
REQ-016 MEM_WR SHALL drive MemWrite=1, IorD=1, hold while mem_ready_i=0, retire on mem_ready_i=1.
REQ-017 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=0, ALU_op=4; WB_R SHALL drive RegWrite=1, RegDst=1, MemtoReg=0; retire.
REQ-018 EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=2, ALU_op=2 for op 8 and 7 for op 9; WB_I SHALL drive RegWrite=1, RegDst=0, MemtoReg=0; retire.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALU_op=5, PCWriteCond=1, PCSource=1; retire.
REQ-020 JUMP SHALL drive PCWrite=1, PCSource=2; retire.
REQ-021 Retire SHALL mean: next state FETCH and instr_done_o=1 for exactly that cycle.
REQ-022 TRAP SHALL set trap_o=1, hold all write enables (PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite) at 0, and remain in TRAP until reset.
REQ-023 In every state, any output not listed SHALL be 0.
REQ-024 instr_op_i SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.
REQ-025 Latency SHALL be, with zero-wait memory: lw 5, sw 4, R/addi/sltiu 4, beq 3, j 3 cycles from FETCH entry to the next FETCH.

Reset
REQ-026 While rst_i=0, state SHALL be FETCH and every output, including MemRead_o, instr_done_o and trap_o, SHALL be 0 regardless of clk_i.
REQ-027 Reset asserted mid-instruction SHALL abort it with no further write-enable pulse; the first cycle after release SHALL be FETCH.

Structure
REQ-028 State encodings, ALU_op codes, PCSource/ALUSrcB codes and opcode constants (0, 2, 4, 8, 9, 35, 43) SHALL reside in a shared package.
REQ-029 Next-state logic and state register SHALL be in this module; output decode SHALL be a sub-module multicycle_ctrl_outdec (state + instr_op_i + mem_ready_i -> controls).

Verification
REQ-030 Opcode 0, mem_ready_i=1 constantly -> FETCH,DECODE,EXEC_R,WB_R; RegWrite=1, RegDst=1 in cycle 4; instr_done_o pulses in cycle 4 only.
REQ-031 Opcode 35, mem_ready_i low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with MemRead=1, IorD=1; MEM_WB asserts MemtoReg=1, RegWrite=1; total 7 cycles.
REQ-032 Opcode 4 -> BRANCH cycle shows ALU_op=5, PCWriteCond=1, PCSource=1, PCWrite=0; next FETCH follows.
REQ-033 Opcode 9 then 8 back-to-back -> EXEC_I ALU_op=7 then 2; two instr_done_o pulses 4 cycles apart.
REQ-034 Opcode 63 -> TRAP after DECODE; trap_o=1 held 20 cycles, all write enables 0; rst_i low clears trap_o asynchronously.
REQ-035 rst_i pulsed low during MEM_WR with mem_ready_i=0 -> MemWrite_o drops immediately; after release FETCH with MemRead=1, no MemWrite pulse.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle datapath controller: FSM states, opcodes,
// ALU operation codes, mux selects and the bundled control word.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_ADDI  = 3'd2;
    localparam logic [2:0] ALU_RTYPE = 3'd4;
    localparam logic [2:0] ALU_SUB   = 3'd5;
    localparam logic [2:0] ALU_SLTIU = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Output decode for the multicycle controller: maps the current state (plus the
// opcode captured in DECODE and memory handshake) onto the datapath control word.
module multicycle_ctrl_outdec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] instr_op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only update on the cycle the fetch actually lands
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_RTYPE;
            end
            ST_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (instr_op == OP_SLTIU) ? ALU_SLTIU : ALU_ADDI;
            end
            ST_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register and next-state logic; the control
// word comes from multicycle_ctrl_outdec and is forced to zero while in reset.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       ALUSrcA_o,
    output logic [1:0] PCSource_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALU_op_o,
    output logic       instr_done_o,
    output logic       trap_o
);

    state_t     state;
    state_t     state_next;
    logic [5:0] op_q;
    ctrl_t      ctrl_dec;
    ctrl_t      ctrl;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is captured in DECODE so later states ignore changes on instr_op_i
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q <= OP_RTYPE;
        end else if (state == ST_DECODE) begin
            op_q <= instr_op_i;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:    if (mem_ready_i) state_next = ST_DECODE;
            ST_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE:      state_next = ST_EXEC_R;
                    OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
                    OP_BEQ:        state_next = ST_BRANCH;
                    OP_ADDI,
                    OP_SLTIU:      state_next = ST_EXEC_I;
                    OP_J:          state_next = ST_JUMP;
                    default:       state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: state_next = (instr_op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready_i) state_next = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready_i) state_next = ST_FETCH;
            ST_EXEC_R:   state_next = ST_WB_R;
            ST_EXEC_I:   state_next = ST_WB_I;
            ST_MEM_WB,
            ST_WB_R,
            ST_WB_I,
            ST_BRANCH,
            ST_JUMP:     state_next = ST_FETCH;
            ST_TRAP:     state_next = ST_TRAP;
            default:     state_next = ST_FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state     (state),
        .instr_op  (op_q),
        .mem_ready (mem_ready_i),
        .ctrl      (ctrl_dec)
    );

    // Gating by rst_i keeps every output low during reset, even though the
    // held state is FETCH (which would otherwise drive MemRead)
    assign ctrl = rst_i ? ctrl_dec : CTRL_IDLE;

    assign PCWrite_o     = ctrl.pc_write;
    assign PCWriteCond_o = ctrl.pc_write_cond;
    assign IorD_o        = ctrl.i_or_d;
    assign MemRead_o     = ctrl.mem_read;
    assign MemWrite_o    = ctrl.mem_write;
    assign IRWrite_o     = ctrl.ir_write;
    assign MemtoReg_o    = ctrl.mem_to_reg;
    assign RegWrite_o    = ctrl.reg_write;
    assign RegDst_o      = ctrl.reg_dst;
    assign ALUSrcA_o     = ctrl.alu_src_a;
    assign PCSource_o    = ctrl.pc_source;
    assign ALUSrcB_o     = ctrl.alu_src_b;
    assign ALU_op_o      = ctrl.alu_op;
    assign instr_done_o  = ctrl.instr_done;
    assign trap_o        = ctrl.trap;

endmodule
